// File: rtl/branch_target_buffer_pkg.sv
// Shared types and constants for the fetch-stage branch target buffer.
// Counter encoding and default table depth.
package branch_target_buffer_pkg;

    localparam int BTB_DEPTH = 16;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    localparam ctr_e ALLOC_CTR = WT;

endpackage

// File: rtl/branch_target_buffer_sat_ctr.sv
// 2-bit saturating direction counter next-state logic (btb_sat_ctr).
module btb_sat_ctr
    import branch_target_buffer_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        unique case (1'b1)
            taken_i && (ctr_i != ST):   ctr_o = ctr_i + 2'd1;
            !taken_i && (ctr_i != SNT): ctr_o = ctr_i - 2'd1;
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: fetch lookup, execute resolve and training.
// Optional BTB_STATS_EN adds branch/hit/mispredict counters.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int ENTRIES = BTB_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    output logic        EntryFoundF,
    output logic [31:0] PredictedPCF,
    input  logic        UpdateEnE,
    input  logic        BranchE,
    input  logic        PCSrcE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [31:0] PCBranchE,
    input  logic        EntryFoundE,
    input  logic [31:0] PredictedPCE,
    output logic        MispredictE,
    output logic [31:0] CorrectPCE
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] StatBranches,
    output logic [31:0] StatHits,
    output logic [31:0] StatMispredicts
`endif
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDXW;

    logic            valid_q  [ENTRIES];
    logic [TAGW-1:0] tag_q    [ENTRIES];
    logic [31:0]     target_q [ENTRIES];
    logic [1:0]      ctr_q    [ENTRIES];

    logic [IDXW-1:0] fidx;
    logic [TAGW-1:0] ftag;
    logic            fhit;

    assign fidx = PCF[IDXW+1:2];
    assign ftag = PCF[31:IDXW+2];
    assign fhit = valid_q[fidx] && (tag_q[fidx] == ftag);

    assign EntryFoundF  = fhit;
    assign PredictedPCF = (fhit && ctr_q[fidx][1]) ? target_q[fidx]
                                                   : PCF + 32'd4;

    logic [31:0] actual_pc;
    logic [31:0] guess_pc;

    assign actual_pc = (BranchE && PCSrcE) ? PCBranchE : PCPlus4E;
    assign guess_pc  = EntryFoundE ? PredictedPCE : PCPlus4E;

    assign MispredictE = (actual_pc != guess_pc);
    assign CorrectPCE  = actual_pc;

    logic [IDXW-1:0] eidx;
    logic [TAGW-1:0] etag;
    logic            ehit;
    logic [1:0]      ctr_nxt;

    assign eidx = PCE[IDXW+1:2];
    assign etag = PCE[31:IDXW+2];
    assign ehit = valid_q[eidx] && (tag_q[eidx] == etag);

    btb_sat_ctr u_sat_ctr (
        .ctr_i   (ctr_q[eidx]),
        .taken_i (PCSrcE),
        .ctr_o   (ctr_nxt)
    );

    logic            we_d;
    logic            valid_d;
    logic [TAGW-1:0] tag_d;
    logic [31:0]     target_d;
    logic [1:0]      ctr_d;

    always_comb begin
        we_d     = 1'b0;
        valid_d  = valid_q[eidx];
        tag_d    = tag_q[eidx];
        target_d = target_q[eidx];
        ctr_d    = ctr_q[eidx];
        if (UpdateEnE) begin
            unique case (1'b1)
                BranchE && ehit: begin
                    we_d  = 1'b1;
                    ctr_d = ctr_nxt;
                    if (PCSrcE) target_d = PCBranchE;
                end
                BranchE && !ehit && PCSrcE: begin
                    we_d     = 1'b1;
                    valid_d  = 1'b1;
                    tag_d    = etag;
                    target_d = PCBranchE;
                    ctr_d    = ALLOC_CTR;
                end
                // Non-branch hitting an entry: stale or aliased, drop it.
                !BranchE && ehit: begin
                    we_d    = 1'b1;
                    valid_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= SNT;
            end
        end else if (we_d) begin
            valid_q[eidx]  <= valid_d;
            tag_q[eidx]    <= tag_d;
            target_q[eidx] <= target_d;
            ctr_q[eidx]    <= ctr_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] br_q, hit_q, mp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_q  <= '0;
            hit_q <= '0;
            mp_q  <= '0;
        end else if (UpdateEnE) begin
            if (BranchE) br_q <= br_q + 32'd1;
            if (BranchE && EntryFoundE) hit_q <= hit_q + 32'd1;
            if (MispredictE) mp_q <= mp_q + 32'd1;
        end
    end

    assign StatBranches    = br_q;
    assign StatHits        = hit_q;
    assign StatMispredicts = mp_q;
`endif

    logic unused_pc_bits;
    assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed vectors,
// randomized traffic against a behavioural model, async reset check.
module tb_branch_target_buffer;

    localparam int ENTRIES = 16;

    logic        clk;
    logic        reset;
    logic [31:0] PCF;
    logic        EntryFoundF;
    logic [31:0] PredictedPCF;
    logic        UpdateEnE, BranchE, PCSrcE;
    logic [31:0] PCE, PCPlus4E, PCBranchE;
    logic        EntryFoundE;
    logic [31:0] PredictedPCE;
    logic        MispredictE;
    logic [31:0] CorrectPCE;
`ifdef BTB_STATS_EN
    logic [31:0] StatBranches, StatHits, StatMispredicts;
`endif

    branch_target_buffer #(.ENTRIES(ENTRIES)) dut (
        .clk          (clk),
        .reset        (reset),
        .PCF          (PCF),
        .EntryFoundF  (EntryFoundF),
        .PredictedPCF (PredictedPCF),
        .UpdateEnE    (UpdateEnE),
        .BranchE      (BranchE),
        .PCSrcE       (PCSrcE),
        .PCE          (PCE),
        .PCPlus4E     (PCPlus4E),
        .PCBranchE    (PCBranchE),
        .EntryFoundE  (EntryFoundE),
        .PredictedPCE (PredictedPCE),
        .MispredictE  (MispredictE),
        .CorrectPCE   (CorrectPCE)
`ifdef BTB_STATS_EN
        ,
        .StatBranches    (StatBranches),
        .StatHits        (StatHits),
        .StatMispredicts (StatMispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pcf, input logic upd,
                         input logic br, input logic tk,
                         input logic [31:0] pce, input logic [31:0] pc4,
                         input logic [31:0] pcbr, input logic efe,
                         input logic [31:0] ppce);
        PCF = pcf; UpdateEnE = upd; BranchE = br; PCSrcE = tk;
        PCE = pce; PCPlus4E = pc4; PCBranchE = pcbr;
        EntryFoundE = efe; PredictedPCE = ppce;
    endtask

    task automatic chk_stats(input string tag, input int unsigned b,
                             input int unsigned h, input int unsigned m);
`ifdef BTB_STATS_EN
        chk({tag, " StatBranches"}, StatBranches, b);
        chk({tag, " StatHits"}, StatHits, h);
        chk({tag, " StatMispredicts"}, StatMispredicts, m);
`else
        if (b + h + m != 0) ; // counters absent in this build
`endif
    endtask

    typedef struct {
        logic [31:0] pcf;
        logic        upd, br, tk;
        logic [31:0] pce, pc4, pcbr;
        logic        efe;
        logic [31:0] ppce;
        logic        xf;
        logic [31:0] xp;
        logic        xm;
        logic [31:0] xc;
    } vec_t;

    function automatic vec_t mk(
        logic [31:0] pcf, logic upd, logic br, logic tk,
        logic [31:0] pce, logic [31:0] pc4, logic [31:0] pcbr,
        logic efe, logic [31:0] ppce,
        logic xf, logic [31:0] xp, logic xm, logic [31:0] xc);
        vec_t v;
        v.pcf = pcf; v.upd = upd; v.br = br; v.tk = tk;
        v.pce = pce; v.pc4 = pc4; v.pcbr = pcbr;
        v.efe = efe; v.ppce = ppce;
        v.xf = xf; v.xp = xp; v.xm = xm; v.xc = xc;
        return v;
    endfunction

    // Behavioural reference: table of records addressed by plain arithmetic.
    bit          mv   [ENTRIES];
    int unsigned mtag [ENTRIES];
    logic [31:0] mtgt [ENTRIES];
    int          mctr [ENTRIES];
    int unsigned st_br, st_hit, st_mp;

    function automatic int unsigned m_idx(logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned m_tag(logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return mv[m_idx(pc)] && mtag[m_idx(pc)] == m_tag(pc);
    endfunction

    function automatic logic [31:0] m_pred(logic [31:0] pc);
        if (m_hit(pc) && mctr[m_idx(pc)] >= 2) return mtgt[m_idx(pc)];
        return pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; mctr[i] = 0;
        end
        st_br = 0; st_hit = 0; st_mp = 0;
    endtask

    task automatic m_update(logic upd, logic br, logic tk,
                            logic [31:0] pce, logic [31:0] pcbr,
                            logic efe, logic mp);
        int unsigned i;
        i = m_idx(pce);
        if (!upd) return;
        if (br) st_br++;
        if (br && efe) st_hit++;
        if (mp) st_mp++;
        if (br && m_hit(pce)) begin
            mctr[i] = tk ? (mctr[i] == 3 ? 3 : mctr[i] + 1)
                         : (mctr[i] == 0 ? 0 : mctr[i] - 1);
            if (tk) mtgt[i] = pcbr;
        end else if (br && tk) begin
            mv[i] = 1; mtag[i] = m_tag(pce); mtgt[i] = pcbr; mctr[i] = 2;
        end else if (!br && m_hit(pce)) begin
            mv[i] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    localparam logic [31:0] A  = 32'h0040_0010, A4 = 32'h0040_0014;
    localparam logic [31:0] T  = 32'h0040_0100, T2 = 32'h0040_0200;
    localparam logic [31:0] B  = 32'h0040_0050, B4 = 32'h0040_0054;
    localparam logic [31:0] C  = 32'h0040_0080, C4 = 32'h0040_0084;
    localparam logic [31:0] Z  = 32'h0;

    vec_t vt[$];

    initial begin
        logic [31:0] pcf, pce, pcbr, ppce, xp, xc, live_pc, np;
        logic upd, br, tk, efe, xf, xm;

        reset = 1'b1;
        drive(A, 0, 0, 0, Z, Z, Z, 0, Z);
        #1;
        chk("reset found", 32'(EntryFoundF), 32'd0);
        chk("reset pred", PredictedPCF, A4);
        chk("reset misp", 32'(MispredictE), 32'd0);
        chk_stats("reset", 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        vt.push_back(mk(A, 0, 0, 0, Z, Z, Z,    0, Z,  0, A4, 0, Z));
        vt.push_back(mk(A, 1, 1, 1, A, A4, T,   0, Z,  0, A4, 1, T));
        vt.push_back(mk(A, 1, 1, 0, A, A4, T,   1, T,  1, T,  1, A4));
        vt.push_back(mk(A, 1, 1, 0, A, A4, T,   1, A4, 1, A4, 0, A4));
        vt.push_back(mk(A, 0, 0, 0, Z, Z, Z,    0, Z,  1, A4, 0, Z));
        vt.push_back(mk(A, 1, 1, 1, A, A4, T,   1, A4, 1, A4, 1, T));
        vt.push_back(mk(A, 1, 1, 1, A, A4, T,   1, A4, 1, A4, 1, T));
        vt.push_back(mk(A, 1, 1, 1, A, A4, T,   1, T,  1, T,  0, T));
        vt.push_back(mk(A, 1, 1, 1, A, A4, T,   1, T,  1, T,  0, T));
        vt.push_back(mk(A, 1, 1, 0, A, A4, T,   1, T,  1, T,  1, A4));
        vt.push_back(mk(A, 0, 0, 0, Z, Z, Z,    0, Z,  1, T,  0, Z));
        vt.push_back(mk(A, 0, 1, 0, A, A4, T,   1, T,  1, T,  1, A4));
        vt.push_back(mk(A, 0, 1, 0, A, A4, T,   1, T,  1, T,  1, A4));
        vt.push_back(mk(A, 1, 1, 1, B, B4, T2,  0, Z,  1, T,  1, T2));
        vt.push_back(mk(A, 0, 0, 0, Z, Z, Z,    0, Z,  0, A4, 0, Z));
        vt.push_back(mk(B, 0, 0, 0, Z, Z, Z,    0, Z,  1, T2, 0, Z));
        vt.push_back(mk(B, 1, 0, 0, B, B4, Z,   1, T2, 1, T2, 1, B4));
        vt.push_back(mk(B, 0, 0, 0, Z, Z, Z,    0, Z,  0, B4, 0, Z));
        vt.push_back(mk(32'hFFFF_FFFC, 0, 0, 0, Z, Z, Z, 0, Z, 0, Z, 0, Z));
        vt.push_back(mk(C, 1, 1, 0, C, C4, T,   0, Z,  0, C4, 0, C4));
        vt.push_back(mk(C, 0, 0, 0, Z, Z, Z,    0, Z,  0, C4, 0, Z));

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            drive(vt[i].pcf, vt[i].upd, vt[i].br, vt[i].tk, vt[i].pce,
                  vt[i].pc4, vt[i].pcbr, vt[i].efe, vt[i].ppce);
            #1;
            chk($sformatf("v%0d found", i), 32'(EntryFoundF), 32'(vt[i].xf));
            chk($sformatf("v%0d pred", i), PredictedPCF, vt[i].xp);
            chk($sformatf("v%0d misp", i), 32'(MispredictE), 32'(vt[i].xm));
            chk($sformatf("v%0d correct", i), CorrectPCE, vt[i].xc);
        end
        @(negedge clk);
        drive(A, 0, 0, 0, Z, Z, Z, 0, Z);
        #1;
        chk_stats("directed", 10, 7, 7);

        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            pcf = 32'h0040_0000 + 32'($urandom_range(0, 63)) * 4;
            pce = 32'h0040_0000 + 32'($urandom_range(0, 63)) * 4;
            pcbr = $urandom() & 32'hFFFF_FFFC;
            upd = ($urandom_range(0, 9) < 8);
            br = ($urandom_range(0, 9) < 7);
            tk = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) != 0) begin
                efe = m_hit(pce);
                ppce = m_pred(pce);
            end else begin
                efe = $urandom_range(0, 1) == 1;
                ppce = $urandom() & 32'hFFFF_FFFC;
            end
            np = pce + 32'd4;
            if ($urandom_range(0, 9) == 0) begin
                upd = 0; br = 0; tk = 0; pce = Z; np = Z;
                pcbr = Z; efe = 0; ppce = Z;
            end
            xf = m_hit(pcf);
            xp = m_pred(pcf);
            xc = (br && tk) ? pcbr : np;
            xm = xc != (efe ? ppce : np);
            drive(pcf, upd, br, tk, pce, np, pcbr, efe, ppce);
            #1;
            chk($sformatf("r%0d found", n), 32'(EntryFoundF), 32'(xf));
            chk($sformatf("r%0d pred", n), PredictedPCF, xp);
            chk($sformatf("r%0d misp", n), 32'(MispredictE), 32'(xm));
            chk($sformatf("r%0d correct", n), CorrectPCE, xc);
            chk_stats($sformatf("r%0d", n), st_br, st_hit, st_mp);
            m_update(upd, br, tk, pce, pcbr, efe, xm);
        end

        live_pc = 32'h0040_0000;
        for (int i = 0; i < ENTRIES; i++)
            if (mv[i]) live_pc = mtag[i] * (4 * ENTRIES) + i * 4;
        @(negedge clk);
        drive(live_pc, 1, 1, 1, 32'h0050_0000, 32'h0050_0004,
              32'h0060_0000, 0, Z);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset found", 32'(EntryFoundF), 32'd0);
        chk("async reset pred", PredictedPCF, live_pc + 32'd4);
        chk("async reset misp", 32'(MispredictE), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(32'h0050_0000, 0, 0, 0, Z, Z, Z, 0, Z);
        #1;
        chk("no write in reset", 32'(EntryFoundF), 32'd0);
        chk("no write in reset pred", PredictedPCF, 32'h0050_0004);
        chk_stats("after reset", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
